// File: rtl/cpu_pkg.sv
// Shared opcode constants and instruction-class helper for the decode stage.
package cpu_pkg;

  localparam logic [3:0] OP_REL     = 4'b0001;
  localparam logic [3:0] OP_JMP     = 4'b1110;
  localparam logic [3:0] OP_JNZ     = 4'b1111;
  localparam logic [2:0] ALU_PREFIX = 3'b110;
  localparam logic [1:0] MOV_PREFIX = 2'b10;

  localparam logic [7:0] NOP_C8   = 8'hC8;
  localparam logic [7:0] NOP_CF   = 8'hCF;
  localparam logic [7:0] NOP_D8   = 8'hD8;
  localparam logic [7:0] NOP_DF   = 8'hDF;
  localparam logic [7:0] IR_RESET = 8'hC8;

  typedef enum logic [2:0] {
    CLS_LD    = 3'd0,
    CLS_REL   = 3'd1,
    CLS_MOV   = 3'd2,
    CLS_ALU   = 3'd3,
    CLS_JMP   = 3'd4,
    CLS_JNZ   = 3'd5,
    CLS_OTHER = 3'd6
  } insn_class_e;

  // Relative branch shares the ir[7]=0 space with loads and takes priority.
  function automatic insn_class_e decode_class(input logic [7:0] word);
    insn_class_e cls;
    if (word[7:4] == OP_REL) begin
      cls = CLS_REL;
    end else if (word[7] == 1'b0) begin
      cls = CLS_LD;
    end else if (word[7:6] == MOV_PREFIX) begin
      cls = CLS_MOV;
    end else if (word[7:5] == ALU_PREFIX) begin
      cls = CLS_ALU;
    end else if (word[7:4] == OP_JMP) begin
      cls = CLS_JMP;
    end else if (word[7:4] == OP_JNZ) begin
      cls = CLS_JNZ;
    end else begin
      cls = CLS_OTHER;
    end
    return cls;
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter: increments on inc, sticks at all-ones, clears on reset.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         sync_reset_n,
  input  logic         inc,
  output logic [W-1:0] count
);

  // Count register with saturation at the maximum value.
  always_ff @(posedge clk) begin
    if (!sync_reset_n) begin
      count <= {W{1'b0}};
    end else if (inc && (count != {W{1'b1}})) begin
      count <= count + W'(1);
    end else begin
      count <= count;
    end
  end

endmodule

// File: rtl/instruction_decoder.sv
// Instruction register, combinational decode, zero flag and performance counters
// sitting between program memory and the sequencer.
module instruction_decoder
  import cpu_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             sync_reset_n,
  input  logic [7:0]       pm_data,
  input  logic             alu_zero,
  output logic [7:0]       ir,
  output logic             jmp,
  output logic             jmp_nz,
  output logic             dont_jmp,
  output logic [3:0]       jmp_addr,
  output logic             ld_en,
  output logic [2:0]       ld_dst,
  output logic [3:0]       imm,
  output logic             mov_en,
  output logic [2:0]       mov_dst,
  output logic [2:0]       mov_src,
  output logic             alu_en,
  output logic [2:0]       alu_func,
  output logic             alu_src_sel,
  output logic             alu_dst_sel,
  output logic             NOPC8,
  output logic             NOPCF,
  output logic             NOPD8,
  output logic             NOPDF,
  output logic             rel_br,
  output logic [CNT_W-1:0] instr_count,
  output logic [CNT_W-1:0] xfer_count
);

  logic [7:0]  ir_r;
  logic        zf_r;
  logic        xfer_inc_s;
  insn_class_e cls_s;

  // Instruction register: one-cycle capture of the program-memory word.
  always_ff @(posedge clk) begin
    if (!sync_reset_n) begin
      ir_r <= IR_RESET;
    end else begin
      ir_r <= pm_data;
    end
  end

  // Zero flag is written only by real ALU operations, so NOPs leave it intact.
  always_ff @(posedge clk) begin
    if (!sync_reset_n) begin
      zf_r <= 1'b0;
    end else if (alu_en) begin
      zf_r <= alu_zero;
    end else begin
      zf_r <= zf_r;
    end
  end

  assign cls_s       = decode_class(ir_r);
  assign ir          = ir_r;
  assign dont_jmp    = zf_r;
  assign jmp_addr    = ir_r[3:0];
  assign imm         = ir_r[3:0];
  assign ld_dst      = ir_r[6:4];
  assign mov_dst     = ir_r[5:3];
  assign mov_src     = ir_r[2:0];
  assign alu_func    = ir_r[2:0];
  assign alu_src_sel = ir_r[3];
  assign alu_dst_sel = ir_r[4];

  // Class decode; the four NOP words sit inside the ALU space and mask alu_en.
  always_comb begin
    rel_br = 1'b0;
    ld_en  = 1'b0;
    mov_en = 1'b0;
    alu_en = 1'b0;
    jmp    = 1'b0;
    jmp_nz = 1'b0;
    NOPC8  = 1'b0;
    NOPCF  = 1'b0;
    NOPD8  = 1'b0;
    NOPDF  = 1'b0;
    case (cls_s)
      CLS_REL: rel_br = 1'b1;
      CLS_LD:  ld_en  = 1'b1;
      CLS_MOV: mov_en = 1'b1;
      CLS_ALU: begin
        case (ir_r)
          NOP_C8:  NOPC8  = 1'b1;
          NOP_CF:  NOPCF  = 1'b1;
          NOP_D8:  NOPD8  = 1'b1;
          NOP_DF:  NOPDF  = 1'b1;
          default: alu_en = 1'b1;
        endcase
      end
      CLS_JMP: jmp    = 1'b1;
      CLS_JNZ: jmp_nz = 1'b1;
      default: begin
        rel_br = 1'b0;
      end
    endcase
  end

  assign xfer_inc_s = jmp | (jmp_nz & ~zf_r) | rel_br;

  sat_counter #(.W(CNT_W)) u_instr_cnt (
    .clk          (clk),
    .sync_reset_n (sync_reset_n),
    .inc          (1'b1),
    .count        (instr_count)
  );

  sat_counter #(.W(CNT_W)) u_xfer_cnt (
    .clk          (clk),
    .sync_reset_n (sync_reset_n),
    .inc          (xfer_inc_s),
    .count        (xfer_count)
  );

endmodule
